matadd_requester: RTL and testbench

//  Initiator side of the matrix-adder strobe/ready/ack protocol used by tbt_adder / fbf_adder.
//  - Accepts A then B as a 32-bit element stream, row-major.
//  - Presents both operands to an NxN float adder, runs the four-phase handshake and captures the result.
//  - Returns the result on an output element stream.
//  - Sits between a streaming datapath (e.g. DMA/UART) and the adder.

---
 rtl/matadd_pkg.sv | 23 ++
 rtl/matadd_elem_counter.sv | 39 +++
 rtl/matadd_requester.sv | 178 +++++++++++++++++
 tb/tb_matadd_requester.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matadd_pkg.sv
// Shared types and helpers for the matrix-adder requester.
package matadd_pkg;

    localparam int unsigned EW = 32;

    typedef enum logic [2:0] {
        ST_LOAD_A,
        ST_LOAD_B,
        ST_REQ,
        ST_ACK,
        ST_UNLOAD
    } state_e;

    // Bit offset of element k inside a packed operand bus.
    function automatic int unsigned elem_lsb(input int unsigned k);
        return EW * k;
    endfunction

    function automatic int unsigned idx_width(input int unsigned nn);
        return (nn > 1) ? $clog2(nn) : 1;
    endfunction

endpackage

// File: rtl/matadd_elem_counter.sv
// Element index counter shared by the load and unload phases; wraps after element N*N-1.
module matadd_elem_counter
    import matadd_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = idx_width(N * N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          inc_i,
    output logic [IW-1:0] idx_o,
    output logic [IW-1:0] idx_nxt_c_o,
    output logic          last_c_o
);

    localparam int unsigned NN = N * N;

    logic [IW-1:0] idx_q, idx_d;

    assign last_c_o    = (idx_q == IW'(NN - 1));
    assign idx_o       = idx_q;
    assign idx_nxt_c_o = idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (inc_i) begin
            idx_d = last_c_o ? '0 : idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idx_q <= '0;
        else        idx_q <= idx_d;
    end

endmodule

// File: rtl/matadd_requester.sv
// Initiator for the matrix-adder strobe/ready/ack handshake: streams A and B in, results out.
// Optional REQ watchdog with err_o output when MATADD_TIMEOUT_EN is defined.
module matadd_requester
    import matadd_pkg::*;
#(
    parameter int unsigned N = 2
`ifdef MATADD_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [EW-1:0]     in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [EW-1:0]     out_data_o,
    output logic              a_stb_o,
    output logic              b_stb_o,
    output logic [EW*N*N-1:0] a_o,
    output logic [EW*N*N-1:0] b_o,
    input  logic              result_ready_i,
    output logic              result_ack_o,
    input  logic [EW*N*N-1:0] result_i,
    output logic              busy_o
`ifdef MATADD_TIMEOUT_EN
    , output logic            err_o
`endif
);

    localparam int unsigned NN = N * N;
    localparam int unsigned IW = idx_width(NN);
    localparam int unsigned BW = EW * NN;

    state_e        state_q, state_d;
    logic [BW-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [EW-1:0] out_data_q, out_data_d;
    logic          in_ready_q, in_ready_d, stb_q, stb_d, ack_q, ack_d;
    logic          out_valid_q, out_valid_d, busy_q, busy_d;
    logic          cnt_clear, cnt_inc, cnt_last;
    logic [IW-1:0] cnt_idx, cnt_nxt;

`ifdef MATADD_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_q, to_d;
    logic          err_q, err_d;
`endif

    matadd_elem_counter #(
        .N  (N),
        .IW (IW)
    ) u_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (cnt_clear),
        .inc_i       (cnt_inc),
        .idx_o       (cnt_idx),
        .idx_nxt_c_o (cnt_nxt),
        .last_c_o    (cnt_last)
    );

    // Next state, operand/result capture and index control.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        cnt_inc   = 1'b0;
        cnt_clear = (state_q == ST_REQ) || (state_q == ST_ACK);
`ifdef MATADD_TIMEOUT_EN
        err_d     = 1'b0;
`endif
        case (state_q)
            ST_LOAD_A: begin
                if (in_valid_i && in_ready_q) begin
                    a_d[elem_lsb(32'(cnt_idx)) +: EW] = in_data_i;
                    cnt_inc = 1'b1;
                    if (cnt_last) state_d = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                if (in_valid_i && in_ready_q) begin
                    b_d[elem_lsb(32'(cnt_idx)) +: EW] = in_data_i;
                    cnt_inc = 1'b1;
                    if (cnt_last) state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (result_ready_i) begin
                    res_d   = result_i;
                    state_d = ST_ACK;
                end
`ifdef MATADD_TIMEOUT_EN
                else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_LOAD_A;
                    err_d   = 1'b1;
                end
`endif
            end
            ST_ACK: begin
                if (!result_ready_i) state_d = ST_UNLOAD;
            end
            ST_UNLOAD: begin
                if (out_ready_i) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) state_d = ST_LOAD_A;
                end
            end
            default: state_d = ST_LOAD_A;
        endcase
`ifdef MATADD_TIMEOUT_EN
        to_d = ((state_q == ST_REQ) && (state_d == ST_REQ)) ? to_q + TW'(1) : '0;
`endif
    end

    // Registered outputs follow the state being entered.
    always_comb begin
        in_ready_d  = (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);
        stb_d       = (state_d == ST_REQ);
        ack_d       = (state_d == ST_ACK);
        out_valid_d = (state_d == ST_UNLOAD);
        busy_d      = !((state_d == ST_LOAD_A) && (cnt_nxt == '0));
        out_data_d  = out_data_q;
        if (state_d == ST_UNLOAD) out_data_d = res_d[elem_lsb(32'(cnt_nxt)) +: EW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD_A;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b0;
            stb_q       <= 1'b0;
            ack_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            stb_q       <= stb_d;
            ack_q       <= ack_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef MATADD_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            to_q  <= to_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

    assign in_ready_o   = in_ready_q;
    assign a_stb_o      = stb_q;
    assign b_stb_o      = stb_q;
    assign result_ack_o = ack_q;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign busy_o       = busy_q;
    assign a_o          = a_q;
    assign b_o          = b_q;

endmodule

// File: tb/tb_matadd_requester.sv
// Directed bench for matadd_requester: N=2 handshake scenarios plus an N=4 randomised stream.
module tb_matadd_requester;

    localparam int unsigned EW  = 32;
    localparam int unsigned BW2 = EW * 4;
    localparam int unsigned BW4 = EW * 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           in_valid, in_ready, out_valid, out_ready;
    logic           a_stb, b_stb, result_ready, result_ack, busy;
    logic [EW-1:0]  in_data, out_data;
    logic [BW2-1:0] a_bus, b_bus, result;

    logic           in_valid4, in_ready4, out_valid4, out_ready4;
    logic           a_stb4, b_stb4, result_ready4, result_ack4, busy4;
    logic [EW-1:0]  in_data4, out_data4;
    logic [BW4-1:0] a_bus4, b_bus4, result4;
`ifdef MATADD_TIMEOUT_EN
    logic           err, err4;
`endif

    int checks = 0;
    int errors = 0;

    logic [EW-1:0]  vec_ab [8];
    logic [EW-1:0]  v4 [32];
    logic [BW4-1:0] exp_a4, exp_b4, exp_r4;

    matadd_requester #(
        .N (2)
`ifdef MATADD_TIMEOUT_EN
        , .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_data_i      (in_data),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_data_o     (out_data),
        .a_stb_o        (a_stb),
        .b_stb_o        (b_stb),
        .a_o            (a_bus),
        .b_o            (b_bus),
        .result_ready_i (result_ready),
        .result_ack_o   (result_ack),
        .result_i       (result),
        .busy_o         (busy)
`ifdef MATADD_TIMEOUT_EN
        , .err_o        (err)
`endif
    );

    matadd_requester #(
        .N (4)
`ifdef MATADD_TIMEOUT_EN
        , .TIMEOUT_CYCLES (16)
`endif
    ) dut4 (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid_i     (in_valid4),
        .in_ready_o     (in_ready4),
        .in_data_i      (in_data4),
        .out_valid_o    (out_valid4),
        .out_ready_i    (out_ready4),
        .out_data_o     (out_data4),
        .a_stb_o        (a_stb4),
        .b_stb_o        (b_stb4),
        .a_o            (a_bus4),
        .b_o            (b_bus4),
        .result_ready_i (result_ready4),
        .result_ack_o   (result_ack4),
        .result_i       (result4),
        .busy_o         (busy4)
`ifdef MATADD_TIMEOUT_EN
        , .err_o        (err4)
`endif
    );

    task automatic chk(input string tag, input logic [BW4-1:0] obs, input logic [BW4-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [EW-1:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_wait", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic stream2();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("pre_last_a_stb", a_stb, 1'b0);
            send(vec_ab[i]);
        end
    endtask

    task automatic recv(input string tag, input logic [EW-1:0] exp);
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk(tag, out_data, exp);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int  k, j, n, cyc, bad_rdy;
        bit  hold, dropped, acc;
        logic [EW-1:0] prev;

        in_valid = 1'b0;  in_data = '0;  out_ready = 1'b0;  result_ready = 1'b0;  result = '0;
        in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b0; result_ready4 = 1'b0; result4 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_a_stb", a_stb, 1'b0);
        chk("rst_b_stb", b_stb, 1'b0);
        chk("rst_ack", result_ack, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_a_bus", a_bus, '0);
        chk("rst_out_data", out_data, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1'b1);
        chk("rel_busy", busy, 1'b0);

        // N=2 transaction with the tbt_adder vectors
        vec_ab = '{32'h40BAE148, 32'h41028F5C, 32'hC040A3D7, 32'hC1200000,
                   32'h41A73333, 32'hC14CCCCD, 32'h4115999A, 32'h40000000};
        stream2();
        chk("t2_a_stb_rise", a_stb, 1'b1);
        chk("t2_b_stb_rise", b_stb, 1'b1);
        chk("t2_a_bus", a_bus, 128'hC1200000_C040A3D7_41028F5C_40BAE148);
        chk("t2_b_bus", b_bus, 128'h40000000_4115999A_C14CCCCD_41A73333);
        chk("t2_in_ready_req", in_ready, 1'b0);
        chk("t2_busy", busy, 1'b1);
        repeat (2) @(negedge clk);
        chk("t2_stb_wait", a_stb, 1'b1);
        chk("t2_ack_wait", result_ack, 1'b0);
        result       = 128'hC1000000_40CAE148_C0947AE1_41D5EB85;
        result_ready = 1'b1;
        @(negedge clk);
        chk("t2_a_stb_drop", a_stb, 1'b0);
        chk("t2_b_stb_drop", b_stb, 1'b0);
        chk("t2_ack_rise", result_ack, 1'b1);
        chk("t2_no_out_in_ack", out_valid, 1'b0);
        result_ready = 1'b0;
        result       = '0;
        @(negedge clk);
        chk("t2_ack_fall", result_ack, 1'b0);
        recv("t2_out0", 32'h41D5EB85);
        recv("t2_out1", 32'hC0947AE1);
        recv("t2_out2", 32'h40CAE148);
        recv("t2_out3", 32'hC1000000);
        chk("t2_done_valid", out_valid, 1'b0);
        chk("t2_done_in_ready", in_ready, 1'b1);
        chk("t2_done_busy", busy, 1'b0);

        // N=4 with random in_valid / out_ready
        for (int i = 0; i < 32; i++) v4[i] = $urandom;
        for (int i = 0; i < 16; i++) begin
            exp_a4[EW*i +: EW] = v4[i];
            exp_b4[EW*i +: EW] = v4[16+i];
            exp_r4[EW*i +: EW] = v4[i] ^ v4[16+i];
        end
        k = 0; cyc = 0;
        while (k < 32 && cyc < 1000) begin
            in_valid4 = 1'($urandom_range(0, 1));
            in_data4  = v4[k];
            acc = in_valid4 && in_ready4;
            @(negedge clk);
            cyc++;
            if (acc) k++;
        end
        in_valid4 = 1'b0;
        chk("t3_loaded", 32'(k), 32'd32);
        chk("t3_a_stb", a_stb4, 1'b1);
        chk("t3_a_bus", a_bus4, exp_a4);
        chk("t3_b_bus", b_bus4, exp_b4);
        bad_rdy = 0;
        result4 = exp_r4;
        result_ready4 = 1'b1;
        n = 0;
        while (!result_ack4 && n < 50) begin
            if (in_ready4) bad_rdy++;
            @(negedge clk);
            n++;
        end
        chk("t3_ack", result_ack4, 1'b1);
        result_ready4 = 1'b0;
        result4 = '1;
        j = 0; cyc = 0; hold = 1'b0; prev = '0;
        while (j < 16 && cyc < 2000) begin
            if (in_ready4) bad_rdy++;
            out_ready4 = 1'($urandom_range(0, 1));
            if (out_valid4) begin
                if (hold) chk("t3_stable", out_data4, prev);
                if (out_ready4) begin
                    chk("t3_out", out_data4, exp_r4[EW*j +: EW]);
                    j++;
                end
                hold = !out_ready4;
                prev = out_data4;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready4 = 1'b0;
        chk("t3_count", 32'(j), 32'd16);
        chk("t3_in_ready_busy_phases", 32'(bad_rdy), 32'd0);
        chk("t3_no_dup", out_valid4, 1'b0);
        chk("t3_in_ready_after", in_ready4, 1'b1);

        // Slow responder, ready held after ack, stray in_valid/out_ready while busy
        vec_ab = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
        stream2();
        in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1;
        dropped = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (!a_stb || out_valid) dropped = 1'b1;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("t4_req_held", dropped, 1'b0);
        chk("t4_a_stable", a_bus, 128'h4_00000003_00000002_00000001);
        chk("t4_b_stable", b_bus, 128'h8_00000007_00000006_00000005);
        result = 128'h11111111_22222222_33333333_44444444;
        result_ready = 1'b1;
        @(negedge clk);
        chk("t4_ack_rise", result_ack, 1'b1);
        chk("t4_stb_drop", a_stb, 1'b0);
        for (int i = 0; i < 3; i++) begin
            result = ~result;
            @(negedge clk);
            chk("t4_ack_held", result_ack, 1'b1);
        end
        result_ready = 1'b0;
        @(negedge clk);
        chk("t4_ack_fall", result_ack, 1'b0);
        recv("t4_out0", 32'h44444444);
        recv("t4_out1", 32'h33333333);
        recv("t4_out2", 32'h22222222);
        recv("t4_out3", 32'h11111111);
        chk("t4_busy_idle", busy, 1'b0);

        // Asynchronous reset mid-REQ, then an immediate-response transaction
        vec_ab = '{32'h40BAE148, 32'h41028F5C, 32'hC040A3D7, 32'hC1200000,
                   32'h41A73333, 32'hC14CCCCD, 32'h4115999A, 32'h40000000};
        stream2();
        chk("t5_in_req", a_stb, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_a_stb", a_stb, 1'b0);
        chk("t5_async_b_stb", b_stb, 1'b0);
        chk("t5_async_busy", busy, 1'b0);
        chk("t5_async_a_bus", a_bus, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_rel_in_ready", in_ready, 1'b1);
        chk("t5_no_out", out_valid, 1'b0);
        result       = 128'hC1000000_40CAE148_C0947AE1_41D5EB85;
        result_ready = 1'b1;
        stream2();
        chk("t5_stb_rise", a_stb, 1'b1);
        chk("t5_no_early_ack", result_ack, 1'b0);
        @(negedge clk);
        chk("t5_imm_ack", result_ack, 1'b1);
        chk("t5_imm_stb_drop", a_stb, 1'b0);
        result_ready = 1'b0;
        result       = '0;
        @(negedge clk);
        recv("t5_out0", 32'h41D5EB85);
        recv("t5_out1", 32'hC0947AE1);
        recv("t5_out2", 32'h40CAE148);
        recv("t5_out3", 32'hC1000000);

        // Responder never ready
        stream2();
        dropped = 1'b0;
`ifdef MATADD_TIMEOUT_EN
        repeat (15) begin
            @(negedge clk);
            if (!a_stb || err) dropped = 1'b1;
        end
        chk("t6_pre_timeout", dropped, 1'b0);
        @(negedge clk);
        chk("t6_err_pulse", err, 1'b1);
        chk("t6_stb_drop", a_stb, 1'b0);
        chk("t6_load_a", in_ready, 1'b1);
        chk("t6_no_out", out_valid, 1'b0);
        @(negedge clk);
        chk("t6_err_clear", err, 1'b0);
        chk("t6_idle", busy, 1'b0);
`else
        repeat (1100) begin
            @(negedge clk);
            if (!a_stb || result_ack || out_valid) dropped = 1'b1;
        end
        chk("t6_waits_in_req", dropped, 1'b0);
        chk("t6_in_ready_low", in_ready, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
